poly_eval: RTL and testbench

POLY_EVAL -- requirements
Module: poly_eval

---
 rtl/poly_eval_pkg.sv | 16 +
 rtl/poly_eval_mac.sv | 20 ++
 rtl/poly_eval.sv | 148 ++++++++++++++
 tb/tb_poly_eval.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/poly_eval_pkg.sv
// Shared definitions for the polynomial evaluator: FSM encoding and counter sizing.
package poly_eval_pkg;

  typedef enum logic [1:0] {
    S_LOAD      = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_COMPUTE   = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  // Width of the idx/step counter, which must reach DEGREE+1.
  function automatic int unsigned cnt_width(input int unsigned degree);
    return $clog2(degree + 2);
  endfunction

endpackage

// File: rtl/poly_eval_mac.sv
// One Horner step: acc*x + coef at full precision, truncated result plus overflow flag.
module poly_eval_mac #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] coef,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam int unsigned FW = 2 * WIDTH + 1;

  logic [FW-1:0] w_full;

  assign w_full = FW'(acc) * FW'(x) + FW'(coef);
  assign sum    = w_full[WIDTH-1:0];
  assign ovf    = |w_full[FW-1:WIDTH];

endmodule

// File: rtl/poly_eval.sv
// Sequential polynomial evaluator: loads DEGREE+1 coefficients and X one strobe at a time,
// then runs DEGREE Horner steps through poly_eval_mac.
module poly_eval
  import poly_eval_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEGREE = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Go,
  input  logic [WIDTH-1:0] DataIn,
  output logic [WIDTH-1:0] DataResult,
  output logic             Done,
  output logic             Busy,
  output logic             Overflow
);

  localparam int unsigned     CW        = cnt_width(DEGREE);
  localparam logic [CW-1:0]   LAST_IDX  = CW'(DEGREE + 1);
  localparam logic [CW-1:0]   STEP_INIT = CW'(DEGREE - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_idx;
  logic [CW-1:0]    r_step;
  logic [WIDTH-1:0] r_coef [DEGREE+1];
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf_acc;
  logic             r_ovf;
  logic             r_done;
  logic             r_busy;

  logic             w_capture;
  logic             w_advance;
  logic             w_start;
  logic             w_compute;
  logic             w_finish;
  logic [WIDTH-1:0] w_coef;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= S_LOAD;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    w_start     = 1'b0;
    w_compute   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (Go) begin
          w_capture   = 1'b1;
          w_state_nxt = S_LOAD_WAIT;
        end
      end
      S_LOAD_WAIT: begin
        if (!Go) begin
          if (r_idx == LAST_IDX) begin
            w_start     = 1'b1;
            w_state_nxt = S_COMPUTE;
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_COMPUTE: begin
        w_compute = 1'b1;
        if (r_step == '0) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_LOAD;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Slot k holds a_(DEGREE-k), so step s reads slot DEGREE-s.
  always_comb begin
    w_coef = '0;
    for (int k = 0; k <= int'(DEGREE); k++) begin
      if (r_step == CW'(int'(DEGREE) - k)) w_coef = r_coef[k];
    end
  end

  poly_eval_mac #(.WIDTH(WIDTH)) u_mac (
    .acc  (r_acc),
    .x    (r_x),
    .coef (w_coef),
    .sum  (w_sum),
    .ovf  (w_ovf)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_idx     <= '0;
      r_step    <= '0;
      r_x       <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_ovf_acc <= 1'b0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      for (int k = 0; k <= int'(DEGREE); k++) r_coef[k] <= '0;
    end else begin
      if (w_capture) begin
        for (int k = 0; k <= int'(DEGREE); k++) begin
          if (r_idx == CW'(k)) r_coef[k] <= DataIn;
        end
        if (r_idx == LAST_IDX) r_x <= DataIn;
      end
      if (w_advance) r_idx <= r_idx + CW'(1);
      if (w_start) begin
        r_acc     <= r_coef[0];
        r_step    <= STEP_INIT;
        r_ovf_acc <= 1'b0;
      end
      if (w_compute) begin
        r_acc     <= w_sum;
        r_ovf_acc <= r_ovf_acc | w_ovf;
        if (r_step != '0) r_step <= r_step - CW'(1);
      end
      if (w_finish) begin
        r_result <= w_sum;
        r_ovf    <= r_ovf_acc | w_ovf;
      end
      if (r_state == S_DONE) r_idx <= '0;
      r_done <= (w_state_nxt == S_DONE);
      r_busy <= (w_state_nxt == S_COMPUTE) || (w_state_nxt == S_DONE);
    end
  end

  assign DataResult = r_result;
  assign Overflow   = r_ovf;
  assign Done       = r_done;
  assign Busy       = r_busy;

endmodule

// File: tb/tb_poly_eval.sv
// Directed bench for poly_eval: DEGREE=2 and DEGREE=3 instances, hand-computed results.
module tb_poly_eval;
  import poly_eval_pkg::*;

  logic       Clock;
  logic       Reset;
  logic       Go2, Go3;
  logic [7:0] Din2, Din3;
  logic [7:0] res2, res3;
  logic       done2, done3, busy2, busy3, ovf2, ovf3;

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  poly_eval #(.WIDTH(8), .DEGREE(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .Go(Go2), .DataIn(Din2),
    .DataResult(res2), .Done(done2), .Busy(busy2), .Overflow(ovf2)
  );

  poly_eval #(.WIDTH(8), .DEGREE(3)) dut3 (
    .Clock(Clock), .Reset(Reset), .Go(Go3), .DataIn(Din3),
    .DataResult(res3), .Done(done3), .Busy(busy3), .Overflow(ovf3)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic load(input int sel, input logic [7:0] v);
    @(negedge Clock);
    if (sel == 2) begin Go2 = 1'b1; Din2 = v; end
    else          begin Go3 = 1'b1; Din3 = v; end
    @(negedge Clock);
    Go2 = 1'b0;
    Go3 = 1'b0;
  endtask

  // Negedges until Done is seen; 0 if it never appears within the bound.
  task automatic wait_done(input int sel, input int bound, output int n);
    n = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge Clock);
      if ((sel == 2) ? done2 : done3) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    Clock = 1'b0; Reset = 1'b1;
    Go2 = 1'b0; Go3 = 1'b0; Din2 = '0; Din3 = '0;
    #12;
    chk("rst_result", 32'(res2), 32'd0);
    chk("rst_done",   32'(done2), 32'd0);
    chk("rst_busy",   32'(busy2), 32'd0);
    chk("rst_ovf",    32'(ovf2), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    // 2x^2+3x+4 at x=5
    load(2, 8'd2); load(2, 8'd3); load(2, 8'd4); load(2, 8'd5);
    @(negedge Clock);
    chk("busy_compute", 32'(busy2), 32'd1);
    wait_done(2, 10, lat);
    chk("lat_deg2", 32'(lat + 1), 32'd3);
    chk("res_69", 32'(res2), 32'd69);
    chk("ovf_69", 32'(ovf2), 32'd0);
    @(negedge Clock);
    chk("done_one_cycle", 32'(done2), 32'd0);
    chk("busy_idle", 32'(busy2), 32'd0);
    repeat (3) @(negedge Clock);
    chk("res_hold", 32'(res2), 32'd69);

    // 16x^2 at x=16 wraps to 0
    load(2, 8'd16); load(2, 8'd0); load(2, 8'd0); load(2, 8'd16);
    wait_done(2, 10, lat);
    chk("lat_ovf", 32'(lat), 32'd3);
    chk("res_wrap", 32'(res2), 32'd0);
    chk("ovf_set", 32'(ovf2), 32'd1);

    // Go held for 10 cycles captures once
    @(negedge Clock);
    Go2 = 1'b1; Din2 = 8'd7;
    repeat (10) @(negedge Clock);
    Go2 = 1'b0;
    @(negedge Clock);
    chk("hold_idx", 32'(dut2.r_idx), 32'd1);
    load(2, 8'd3); load(2, 8'd4); load(2, 8'd5);
    wait_done(2, 10, lat);
    chk("res_194", 32'(res2), 32'd194);
    chk("ovf_clear", 32'(ovf2), 32'd0);

    // Go pulses during compute and done are ignored
    load(2, 8'd2); load(2, 8'd3); load(2, 8'd4); load(2, 8'd5);
    @(negedge Clock);
    Go2 = 1'b1; Din2 = 8'd99;
    @(negedge Clock);
    Go2 = 1'b0;
    @(negedge Clock);
    chk("ign_done", 32'(done2), 32'd1);
    chk("ign_res", 32'(res2), 32'd69);
    Go2 = 1'b1; Din2 = 8'd99;
    @(negedge Clock);
    Go2 = 1'b0;
    chk("ign_idx", 32'(dut2.r_idx), 32'd0);
    chk("ign_state", 32'(dut2.r_state), 32'(S_LOAD));
    load(2, 8'd1); load(2, 8'd1); load(2, 8'd1); load(2, 8'd2);
    wait_done(2, 10, lat);
    chk("res_7", 32'(res2), 32'd7);

    // Asynchronous reset mid-compute
    load(2, 8'd2); load(2, 8'd3); load(2, 8'd4); load(2, 8'd5);
    @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    chk("arst_result", 32'(res2), 32'd0);
    chk("arst_busy",   32'(busy2), 32'd0);
    chk("arst_done",   32'(done2), 32'd0);
    chk("arst_ovf",    32'(ovf2), 32'd0);
    chk("arst_state",  32'(dut2.r_state), 32'(S_LOAD));
    @(negedge Clock);
    Reset = 1'b0;
    wait_done(2, 6, lat);
    chk("arst_no_done", 32'(lat), 32'd0);
    chk("arst_idx", 32'(dut2.r_idx), 32'd0);

    // x^3 at x=3 on the DEGREE=3 instance
    load(3, 8'd1); load(3, 8'd0); load(3, 8'd0); load(3, 8'd0); load(3, 8'd3);
    wait_done(3, 10, lat);
    chk("lat_deg3", 32'(lat), 32'd4);
    chk("res_27", 32'(res3), 32'd27);
    chk("ovf_27", 32'(ovf3), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
